rom_port_arbiter: RTL and testbench

- Shares the single combinational instruction ROM between two requesters: the core's instruction-fetch port (IF) and the data-bus read port (D), used for loading read-only constants.
- Arbitration is round-robin between the two ports.
- Each granted read returns word data, registered, one cycle after the grant.
- Sits between the core/bus and the ROM; drives the ROM address and receives the ROM word.

---
 rtl/rom_port_arbiter.sv | 101 ++++++++++
 tb/tb_rom_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// rom_port_arbiter : round-robin sharing of the instruction ROM between the
//                    fetch (IF) port and the data-bus read (D) port.
// Revision 1.0
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 128,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,

  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic LG_IF = 1'b0;
  localparam logic LG_D  = 1'b1;

  // Widened by one bit so DEPTH*4 == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);

  logic last_grant;
  logic if_bad;
  logic d_bad;

  assign if_bad = ({1'b0, if_addr} >= ADDR_LIMIT) || (if_addr[1:0] != 2'b00);
  assign d_bad  = ({1'b0, d_addr}  >= ADDR_LIMIT) || (d_addr[1:0]  != 2'b00);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && d_req) begin
        if (last_grant == LG_D) begin
          if_gnt = 1'b1;
        end else begin
          d_gnt = 1'b1;
        end
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  always_comb begin
    rom_addr = '0;
    if (if_gnt) begin
      rom_addr = if_addr;
    end else if (d_gnt) begin
      rom_addr = d_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= LG_D;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt;
      if (if_gnt) begin
        last_grant <= LG_IF;
        if_err     <= if_bad;
        if_rdata   <= if_bad ? NOP_WORD : rom_data;
      end
      if (d_gnt) begin
        last_grant <= LG_D;
        d_err      <= d_bad;
        d_rdata    <= d_bad ? '0 : rom_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// ============================================================================
// tb_rom_port_arbiter : directed self-checking bench for rom_port_arbiter.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_rom_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // ROM word i holds 0x1000_0000 + i; beyond the ROM reads back a marker.
  always_comb begin
    if (rom_addr[ADDR_W-1:2] < 10'd128) begin
      rom_data = 32'h1000_0000 + {22'd0, rom_addr[ADDR_W-1:2]};
    end else begin
      rom_data = 32'hDEAD_BEEF;
    end
  end

  rom_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (128),
    .NOP_WORD (32'h00000013)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grants(input string tag, input logic eif, input logic ed, input logic [31:0] eaddr);
    #1;
    check({tag, ".if_gnt"},   {31'd0, if_gnt}, {31'd0, eif});
    check({tag, ".d_gnt"},    {31'd0, d_gnt},  {31'd0, ed});
    check({tag, ".rom_addr"}, {20'd0, rom_addr}, eaddr);
  endtask

  task automatic if_resp(input string tag, input logic [31:0] edata, input logic eerr);
    check({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd1);
    check({tag, ".if_rdata"},  if_rdata, edata);
    check({tag, ".if_err"},    {31'd0, if_err}, {31'd0, eerr});
    check({tag, ".d_rvalid"},  {31'd0, d_rvalid}, 32'd0);
  endtask

  task automatic d_resp(input string tag, input logic [31:0] edata, input logic eerr);
    check({tag, ".d_rvalid"},  {31'd0, d_rvalid}, 32'd1);
    check({tag, ".d_rdata"},   d_rdata, edata);
    check({tag, ".d_err"},     {31'd0, d_err}, {31'd0, eerr});
    check({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = '0;
    d_req   = 1'b1;
    d_addr  = '0;

    // Reset state, with requests already pending
    #2;
    grants("rst", 1'b0, 1'b0, 32'h0);
    check("rst.if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("rst.d_rvalid",  {31'd0, d_rvalid},  32'd0);
    check("rst.if_rdata",  if_rdata, 32'h0);
    check("rst.d_rdata",   d_rdata,  32'h0);
    check("rst.if_err",    {31'd0, if_err}, 32'd0);
    check("rst.d_err",     {31'd0, d_err},  32'd0);
    step();
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b0;

    // D misaligned
    d_req = 1'b1; d_addr = 12'h006;
    grants("dmis", 1'b0, 1'b1, 32'h006);
    step();
    d_req = 1'b0;
    d_resp("dmis", 32'h0, 1'b1);

    // D out of range, then a valid D read
    d_req = 1'b1; d_addr = 12'h200;
    grants("door", 1'b0, 1'b1, 32'h200);
    step();
    d_resp("door", 32'h0, 1'b1);
    d_addr = 12'h00C;
    grants("dok", 1'b0, 1'b1, 32'h00C);
    step();
    d_req = 1'b0;
    d_resp("dok", 32'h1000_0003, 1'b0);

    // Contention after a D grant: IF, D, IF, D
    if_req = 1'b1; if_addr = 12'h010;
    d_req  = 1'b1; d_addr  = 12'h020;
    for (int k = 0; k < 2; k++) begin
      grants("cont_if", 1'b1, 1'b0, 32'h010);
      step();
      if_resp("cont_if", 32'h1000_0004, 1'b0);
      grants("cont_d", 1'b0, 1'b1, 32'h020);
      step();
      d_resp("cont_d", 32'h1000_0008, 1'b0);
    end

    // Withdrawn D request while IF owns the contention
    grants("wd", 1'b1, 1'b0, 32'h010);
    step();
    d_req = 1'b0;
    if_resp("wd", 32'h1000_0004, 1'b0);

    // IF only, consecutive addresses
    for (int k = 0; k < 3; k++) begin
      if_addr = ADDR_W'(k * 4);
      grants("ifonly", 1'b1, 1'b0, 32'(k * 4));
      step();
      if_resp("ifonly", 32'h1000_0000 + 32'(k), 1'b0);
    end

    // IF out of range, then IF misaligned
    if_addr = 12'h200;
    grants("ifoor", 1'b1, 1'b0, 32'h200);
    step();
    if_resp("ifoor", 32'h0000_0013, 1'b1);
    if_addr = 12'h002;
    grants("ifmis", 1'b1, 1'b0, 32'h002);
    step();
    if_req = 1'b0;
    if_resp("ifmis", 32'h0000_0013, 1'b1);

    // Reset arrives while a D response is in flight
    d_req = 1'b1; d_addr = 12'h020;
    grants("rmid", 1'b0, 1'b1, 32'h020);
    step();
    d_req = 1'b0;
    check("rmid.pre.d_rvalid", {31'd0, d_rvalid}, 32'd1);
    reset = 1'b1;
    #1;
    check("rmid.d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rmid.d_rdata",  d_rdata, 32'h0);
    step();
    if_req = 1'b1; if_addr = 12'h004;
    d_req  = 1'b1; d_addr  = 12'h008;
    reset  = 1'b0;
    grants("post_rst_if", 1'b1, 1'b0, 32'h004);
    step();
    if_resp("post_rst_if", 32'h1000_0001, 1'b0);
    grants("post_rst_d", 1'b0, 1'b1, 32'h008);
    step();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_resp("post_rst_d", 32'h1000_0002, 1'b0);

    // Idle: no grants, no responses
    grants("idle", 1'b0, 1'b0, 32'h0);
    step();
    check("idle.if_rvalid", {31'd0, if_rvalid}, 32'd0);
    check("idle.d_rvalid",  {31'd0, d_rvalid},  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
